// File: rtl/pipe_adder_pkg.sv
// Shared definitions for pipe_adder: operation encoding and carry-segment sizing.
package pipe_adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Bits per carry segment; guarded so an illegal STAGES still elaborates far enough to report.
   function automatic int seg_width(input int width, input int stages);
      return (stages > 0) ? width / stages : width;
   endfunction

endpackage

// File: rtl/adder_seg.sv
// adder_seg: one SEG-bit ripple segment of the pipelined adder.
module adder_seg #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);

   logic [SEG:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
   assign sum   = total[SEG-1:0];
   assign cout  = total[SEG];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep carry-segmented adder/subtractor with operand/result skew buffers.
// Defining PIPE_ADDER_OVF_EN adds the signed-overflow output ovf.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDER_OVF_EN
   output logic             carry,
   output logic             ovf
`else
   output logic             carry
`endif
);

   localparam int SEG = seg_width(WIDTH, STAGES);

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0) begin : g_bad_cfg
      $error("pipe_adder: illegal STAGES=%0d for WIDTH=%0d", STAGES, WIDTH);
   end

   // Handshake: a beat moves on every rising edge where valid && ready. The whole pipe
   // advances as one (adv) when the output slot is empty or being taken, so in_ready is
   // a combinational function of out_valid/out_ready and never depends on in_valid.
   logic adv;
   logic is_sub;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign is_sub   = (op_e'(op) == OP_SUB);

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int AW = WIDTH - k * SEG;

      logic [AW-1:0]        a_src;
      logic [AW-1:0]        b_src;
      logic                 c_src;
      logic                 v_src;
      logic [SEG-1:0]       seg_sum;
      logic                 seg_cout;
      logic [(k+1)*SEG-1:0] s_nxt;
      logic [(k+1)*SEG-1:0] s_q;
      logic                 c_q;
      logic                 v_q;

      // SUB folds into the adder as a + ~b + 1; cin only matters for ADD.
      if (k == 0) begin : g_head
         assign a_src = a;
         assign b_src = is_sub ? ~b : b;
         assign c_src = is_sub ? 1'b1 : cin;
         assign v_src = in_valid;
         assign s_nxt = seg_sum;
      end else begin : g_tail
         assign a_src = g_stage[k-1].g_skew.a_q;
         assign b_src = g_stage[k-1].g_skew.b_q;
         assign c_src = g_stage[k-1].c_q;
         assign v_src = g_stage[k-1].v_q;
         assign s_nxt = {seg_sum, g_stage[k-1].s_q};
      end

      adder_seg #(.SEG(SEG)) u_seg (
         .a    (a_src[SEG-1:0]),
         .b    (b_src[SEG-1:0]),
         .cin  (c_src),
         .sum  (seg_sum),
         .cout (seg_cout)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
         end else if (adv) begin
            s_q <= s_nxt;
            c_q <= seg_cout;
            v_q <= v_src;
         end
      end

      // Operand bits above this segment travel with the beat until their stage adds them.
      if (k < STAGES - 1) begin : g_skew
         logic [AW-SEG-1:0] a_q;
         logic [AW-SEG-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_src[AW-1:SEG];
               b_q <= b_src[AW-1:SEG];
            end
         end
      end
   end

   assign sum       = g_stage[STAGES-1].s_q;
   assign carry     = g_stage[STAGES-1].c_q;
   assign out_valid = g_stage[STAGES-1].v_q;

`ifdef PIPE_ADDER_OVF_EN
   // Overflow when both adder operands share a sign that the result does not.
   logic ovf_nxt;
   logic ovf_q;

   assign ovf_nxt = (g_stage[STAGES-1].a_src[SEG-1] == g_stage[STAGES-1].b_src[SEG-1]) &&
                    (g_stage[STAGES-1].seg_sum[SEG-1] != g_stage[STAGES-1].a_src[SEG-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_nxt;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed vectors and corner sequences on a 4-stage pipe_adder, plus random
// streams with random backpressure on 1-stage and 32-stage builds against an arithmetic model.
module tb_pipe_adder;

   localparam int W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst_n;
   logic rand_go = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   main_pops = 0;

   always #5 clk = ~clk;

   // ---------------- main DUT (WIDTH=32, STAGES=4) ----------------
   logic         in_valid, in_ready, op, cin, out_valid, out_ready, carry, ovf_m;
   logic [W-1:0] a, b, sum;
   logic [W+1:0] exp_q[$];

`ifdef PIPE_ADDER_OVF_EN
   logic ovf;
   assign ovf_m = ovf;
`else
   assign ovf_m = 1'b0;
`endif

   pipe_adder #(.WIDTH(W), .STAGES(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .cin       (cin),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
`ifdef PIPE_ADDER_OVF_EN
      .carry     (carry),
      .ovf       (ovf)
`else
      .carry     (carry)
`endif
   );

   // ---------------- helpers ----------------
   function automatic logic [W+1:0] mask_ovf(input logic [W+1:0] m);
`ifdef PIPE_ADDER_OVF_EN
      return m;
`else
      return {1'b0, m[W:0]};
`endif
   endfunction

   // Reference: {ovf, carry, sum} from unsigned/signed integer arithmetic.
   function automatic logic [W+1:0] model(input logic m_op, input logic m_cin,
                                          input logic [W-1:0] m_a, input logic [W-1:0] m_b);
      longint ua, ub, u, sa, sb, r;
      logic [W-1:0] s;
      logic c, v;
      ua = longint'(m_a);
      ub = longint'(m_b);
      sa = longint'($signed(m_a));
      sb = longint'($signed(m_b));
      if (m_op) begin
         u = ua - ub;
         s = u[W-1:0];
         c = (ua >= ub);
         r = sa - sb;
      end else begin
         u = ua + ub + longint'(m_cin);
         s = u[W-1:0];
         c = u[W];
         r = sa + sb + longint'(m_cin);
      end
      v = (r > SMAX) || (r < SMIN);
      return mask_ovf({v, c, s});
   endfunction

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return '1;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return '0;
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic d_op, input logic d_cin, input logic [W-1:0] d_a,
                        input logic [W-1:0] d_b);
      in_valid = 1'b1;
      op       = d_op;
      cin      = d_cin;
      a        = d_a;
      b        = d_b;
   endtask

   // ---------------- main scoreboard ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            main_pops++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL main_sb: got result 0x%0h with no beat outstanding", sum);
            end else begin
               chk("main_sb", {ovf_m, carry, sum}, exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(op, cin, a, b));
      end
   end

   // ---------------- random streams on STAGES=1 and STAGES=32 ----------------
   for (genvar g = 0; g < 2; g++) begin : g_rand
      localparam int ST = (g == 0) ? 1 : 32;

      logic         r_in_valid, r_in_ready, r_op, r_cin, r_out_valid, r_out_ready, r_carry;
      logic         r_ovf_m, done, pending;
      logic [W-1:0] r_a, r_b, r_sum;
      logic [W+1:0] q[$];

`ifdef PIPE_ADDER_OVF_EN
      logic r_ovf;
      assign r_ovf_m = r_ovf;
`else
      assign r_ovf_m = 1'b0;
`endif

      pipe_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (r_in_valid),
         .in_ready  (r_in_ready),
         .op        (r_op),
         .cin       (r_cin),
         .a         (r_a),
         .b         (r_b),
         .out_valid (r_out_valid),
         .out_ready (r_out_ready),
         .sum       (r_sum),
`ifdef PIPE_ADDER_OVF_EN
         .carry     (r_carry),
         .ovf       (r_ovf)
`else
         .carry     (r_carry)
`endif
      );

      always @(negedge clk) begin
         if (!rst_n) begin
            q.delete();
         end else begin
            if (r_out_valid && r_out_ready) begin
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL rand_s%0d_sb: got result 0x%0h with no beat outstanding", ST, r_sum);
               end else begin
                  chk($sformatf("rand_s%0d_sb", ST), {r_ovf_m, r_carry, r_sum}, q.pop_front());
               end
            end
            if (r_in_valid && r_in_ready) q.push_back(model(r_op, r_cin, r_a, r_b));
         end
      end

      initial begin
         r_in_valid  = 1'b0;
         r_out_ready = 1'b0;
         r_op        = 1'b0;
         r_cin       = 1'b0;
         r_a         = '0;
         r_b         = '0;
         done        = 1'b0;
         pending     = 1'b0;
         wait (rand_go);
         @(posedge clk);
         #1;
         for (int n = 0; n < 1000;) begin
            if (!pending) begin
               r_in_valid = ($urandom_range(0, 3) != 0);
               r_op       = 1'($urandom_range(0, 1));
               r_cin      = 1'($urandom_range(0, 1));
               r_a        = rnd_operand();
               r_b        = rnd_operand();
            end
            r_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (r_in_valid && r_in_ready) begin
               n++;
               pending = 1'b0;
            end else begin
               pending = r_in_valid;
            end
            @(posedge clk);
            #1;
         end
         r_in_valid  = 1'b0;
         r_out_ready = 1'b1;
         for (int i = 0; i < 100 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
         end
         chk($sformatf("rand_s%0d_drain", ST), q.size(), 0);
         done = 1'b1;
      end
   end

   // ---------------- directed test ----------------
   typedef struct {
      logic         op;
      logic         cin;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } vec_t;

   vec_t tbl[11];

   initial begin
      logic [W+1:0] exp8[8];
      logic [W+1:0] exp_s[6];
      logic         t_op, t_cin;
      logic [W-1:0] t_a, t_b;
      int           pops0;

      tbl[0]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0001, 1'b0, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 1'b0;
      cin       = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) tick();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_sum", sum, 0);
      chk("reset_carry", carry, 0);
      chk("reset_ovf", ovf_m, 0);
      chk("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;
      tick();
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);

      // single beats: exact 4-cycle latency and fixed results
      foreach (tbl[i]) begin
         drive(tbl[i].op, tbl[i].cin, tbl[i].a, tbl[i].b);
         chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
         tick();
         in_valid = 1'b0;
         repeat (2) tick();
         chk($sformatf("vec%0d_early", i), out_valid, 0);
         tick();
         chk($sformatf("vec%0d_valid", i), out_valid, 1);
         chk($sformatf("vec%0d_sum", i), sum, tbl[i].s);
         chk($sformatf("vec%0d_carry", i), carry, tbl[i].c);
`ifdef PIPE_ADDER_OVF_EN
         chk($sformatf("vec%0d_ovf", i), ovf, tbl[i].v);
`endif
      end
      in_valid = 1'b0;
      tick();

      // eight back-to-back beats emerge on eight consecutive cycles, in order
      for (int c = 0; c < 13; c++) begin
         if (c < 8) begin
            t_op  = 1'($urandom_range(0, 1));
            t_cin = 1'($urandom_range(0, 1));
            t_a   = rnd_operand();
            t_b   = rnd_operand();
            drive(t_op, t_cin, t_a, t_b);
            exp8[c] = model(t_op, t_cin, t_a, t_b);
         end else begin
            in_valid = 1'b0;
         end
         if (c >= 4 && c < 12) begin
            chk($sformatf("b2b_valid_c%0d", c), out_valid, 1);
            chk($sformatf("b2b_data_c%0d", c), {ovf_m, carry, sum}, exp8[c-4]);
         end else begin
            chk($sformatf("b2b_idle_c%0d", c), out_valid, 0);
         end
         tick();
      end

      // stall with a full pipe: outputs frozen, input blocked, nothing lost on release
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         t_op  = 1'($urandom_range(0, 1));
         t_cin = 1'($urandom_range(0, 1));
         t_a   = rnd_operand();
         t_b   = rnd_operand();
         drive(t_op, t_cin, t_a, t_b);
         exp_s[i] = model(t_op, t_cin, t_a, t_b);
         tick();
      end
      drive(1'b0, 1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
      pops0 = main_pops;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("stall_in_ready_%0d", i), in_ready, 0);
         chk($sformatf("stall_valid_%0d", i), out_valid, 1);
         chk($sformatf("stall_hold_%0d", i), {ovf_m, carry, sum}, exp_s[0]);
         tick();
      end
      out_ready = 1'b1;
      tick();
      drive(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0020);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      chk("stall_drain_left", exp_q.size(), 0);
      chk("stall_drain_count", main_pops - pops0, 6);

      // reset with beats in flight and one at the output
      for (int i = 0; i < 5; i++) begin
         drive(1'($urandom_range(0, 1)), 1'b0, rnd_operand(), rnd_operand());
         tick();
      end
      in_valid = 1'b0;
      chk("rst_pre_valid", out_valid, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_carry", carry, 0);
      chk("rst_in_ready", in_ready, 1);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("rst_no_stale_%0d", i), out_valid, 0);
      end
      drive(tbl[7].op, tbl[7].cin, tbl[7].a, tbl[7].b);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_sum", sum, tbl[7].s);
      chk("post_rst_carry", carry, tbl[7].c);
      tick();

      // random streams on the other two builds
      rand_go = 1'b1;
      for (int i = 0; i < 30000 && !(g_rand[0].done && g_rand[1].done); i++) @(posedge clk);
      chk("rand_done", {g_rand[0].done, g_rand[1].done}, 2'b11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #600000;
      failures++;
      $display("FAIL watchdog: got no completion, required completion before time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning pipeline depth and number of carry segments; legal 1..WIDTH with WIDTH % STAGES == 0; illegal values SHALL stop elaboration with $error.
REQ-003 SHALL have port clk  input  1  the single clock; all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-007 SHALL have port op  input  1  operation: 0 = ADD, 1 = SUB.
REQ-008 SHALL have port cin  input  1  carry-in; used for ADD only.
REQ-009 SHALL have ports a and b  input  WIDTH  operands, unsigned bit vectors.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port carry  output  1  carry-out of bit WIDTH-1 (for SUB: 1 = no borrow).

Function
REQ-014 SHALL compute ADD as {carry,sum} = a + b + cin and SUB as {carry,sum} = a + ~b + 1, cin ignored; all arithmetic modulo 2^(WIDTH+1).
REQ-015 SHALL split operands into STAGES segments of SEG = WIDTH/STAGES bits; stage k adds segment k (bits k*SEG+SEG-1..k*SEG) using the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-016 SHALL register upper not-yet-added operand segments and already-produced lower sum segments alongside each stage (skew buffers) so each beat's full result emerges together.
REQ-017 SHALL have latency exactly STAGES cycles from accept to out_valid with no backpressure; STAGES = 1 is a single registered adder.
REQ-018 SHALL sustain one beat per cycle when out_ready is held high.
REQ-019 SHALL use a global advance enable adv = !out_valid || out_ready; every stage register and per-stage valid bit loads only when adv; in_ready = adv.
REQ-020 SHALL hold sum, carry and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL insert bubbles (stage valid = 0) when in_valid is low during adv; bubbles never produce out_valid.
REQ-022 SHALL accept a new beat in the same cycle the final beat is taken (simultaneous accept and drain when adv).
REQ-023 SHALL NOT reorder, drop or duplicate beats; results leave in acceptance order.

Reset
REQ-024 SHALL clear all stage valid bits asynchronously on rst_n low; out_valid = 0, sum = 0, carry = 0 (and ovf = 0 if present) during and after reset.
REQ-025 SHALL discard all in-flight beats on reset mid-operation; first post-reset result is from the first beat accepted after rst_n rises.
REQ-026 SHALL drive in_ready = 1 while in reset-released empty state.

Configuration
REQ-027 SHALL, when PIPE_ADDER_OVF_EN is defined, add port ovf  output  1  signed two's-complement overflow of the operation, aligned with sum and held under stall like sum.
REQ-028 SHALL, without PIPE_ADDER_OVF_EN, have no ovf port and no sign-tracking registers; all other behaviour identical.

Structure
REQ-029 SHALL place the op encoding typedef (ADD/SUB) and a function computing SEG in shared package pipe_adder_pkg.
REQ-030 SHALL implement each segment with one sub-module adder_seg (parameter SEG; inputs a, b, cin; outputs sum, cout), instantiated STAGES times via generate.

Verification
REQ-031 SHALL cover: WIDTH=32, STAGES=4, ADD a=0xFFFFFFFF b=0x00000001 cin=0 -> after 4 cycles sum=0x00000000 carry=1 (carry ripples across all segments).
REQ-032 SHALL cover: SUB a=0x00000005 b=0x00000007 -> sum=0xFFFFFFFE carry=0; with PIPE_ADDER_OVF_EN, ADD a=0x7FFFFFFF b=1 -> ovf=1.
REQ-033 SHALL cover: back-to-back 8 beats with out_ready=1 -> 8 results on 8 consecutive cycles starting cycle 4, in order.
REQ-034 SHALL cover: out_ready=0 for 6 cycles after pipeline fills -> in_ready=0, sum/carry/out_valid unchanged; release -> remaining beats drain, none lost.
REQ-035 SHALL cover: rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately; no stale result after release.
REQ-036 SHALL cover: STAGES=1 and STAGES=32 with 1000 random beats and random out_ready -> every result matches reference model a+b+cin / a-b.
